// File: rtl/complex_pkg.sv
// Shared types and arithmetic for the complex accumulator: FSM state encoding,
// default widths and the shift-and-saturate step applied to each accumulator.
package complex_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    localparam int unsigned IN_W_DEF  = 16;
    localparam int unsigned CNT_W_DEF = 8;
    localparam int unsigned ACC_W_DEF = 24;
    localparam int unsigned OUT_W_DEF = 16;
    localparam int unsigned SHIFT_DEF = 8;

    // Working width of the saturation helper; any ACC_W up to this fits.
    localparam int unsigned SAT_W = 64;

    typedef struct packed {
        logic                    clip;
        logic signed [SAT_W-1:0] val;
    } sat_res_t;

    function automatic sat_res_t shift_sat(
        input logic signed [SAT_W-1:0] acc,
        input int unsigned             shift,
        input int unsigned             out_w
    );
        logic signed [SAT_W-1:0] v;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        sat_res_t                r;
        v     = acc >>> shift;
        max_v = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (v > max_v) begin
            r.clip = 1'b1;
            r.val  = max_v;
        end else if (v < min_v) begin
            r.clip = 1'b1;
            r.val  = min_v;
        end else begin
            r.clip = 1'b0;
            r.val  = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/complex_sat.sv
// Combinational scale-and-clip of one accumulator component down to the
// result width, with a flag when the value had to be clipped.
module complex_sat
    import complex_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic [ACC_W-1:0] acc_i,
    output logic [OUT_W-1:0] res_o,
    output logic             clip_o
);

    logic signed [SAT_W-1:0]   acc_ext_s;
    sat_res_t                  res_s;
    logic [SAT_W-OUT_W-1:0]    val_unused_s;

    // Sign-extend into the helper's working width, then scale and clip.
    always_comb begin
        acc_ext_s    = {{(SAT_W-ACC_W){acc_i[ACC_W-1]}}, acc_i};
        res_s        = shift_sat(acc_ext_s, SHIFT, OUT_W);
        res_o        = res_s.val[OUT_W-1:0];
        val_unused_s = res_s.val[SAT_W-1:OUT_W];
        clip_o       = res_s.clip;
    end

endmodule

// File: rtl/complex_accum.sv
// Frame accumulator for complex products: sums LEN samples into wide
// accumulators and emits one scaled, saturated complex result per frame.
module complex_accum
    import complex_pkg::*;
#(
    parameter int unsigned IN_W  = IN_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned OUT_W = OUT_W_DEF,
    parameter int unsigned SHIFT = SHIFT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_real,
    input  logic [IN_W-1:0]  in_imag,
    output logic             busy,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_real,
    output logic [OUT_W-1:0] out_imag,
    output logic             sat
);

    if (ACC_W < IN_W + CNT_W) begin : g_chk_acc_w
        $error("complex_accum: ACC_W must be at least IN_W+CNT_W");
    end
    if ((OUT_W > ACC_W) || (SHIFT + OUT_W > ACC_W) || (ACC_W > SAT_W)) begin : g_chk_shift
        $error("complex_accum: SHIFT/OUT_W/ACC_W combination out of range");
    end

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [ACC_W-1:0] acc_r_q;
    logic [ACC_W-1:0] acc_i_q;
    logic [ACC_W-1:0] acc_r_d;
    logic [ACC_W-1:0] acc_i_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] len_q;
    logic             last_s;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_real_q;
    logic [OUT_W-1:0] out_imag_q;
    logic             sat_q;
    logic [OUT_W-1:0] res_r_s;
    logic [OUT_W-1:0] res_i_s;
    logic             clip_r_s;
    logic             clip_i_s;

    // Candidate sums and last-sample detect; the saturators see the sum that
    // includes the current sample so the result is ready one cycle later.
    always_comb begin
        acc_r_d = acc_r_q + {{(ACC_W-IN_W){in_real[IN_W-1]}}, in_real};
        acc_i_d = acc_i_q + {{(ACC_W-IN_W){in_imag[IN_W-1]}}, in_imag};
        if ((state_q == ST_ACCUM) && in_valid && (cnt_q == (len_q - CNT_ONE))) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    complex_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_sat_real (
        .acc_i  (acc_r_d),
        .res_o  (res_r_s),
        .clip_o (clip_r_s)
    );

    complex_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_sat_imag (
        .acc_i  (acc_i_d),
        .res_o  (res_i_s),
        .clip_o (clip_i_s)
    );

    // Control FSM, sample counter, accumulators and the result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_r_q     <= {ACC_W{1'b0}};
            acc_i_q     <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            len_q       <= {CNT_W{1'b0}};
            out_valid_q <= 1'b0;
            out_real_q  <= {OUT_W{1'b0}};
            out_imag_q  <= {OUT_W{1'b0}};
            sat_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start && (len != {CNT_W{1'b0}})) begin
                        state_q <= ST_ACCUM;
                        len_q   <= len;
                        acc_r_q <= {ACC_W{1'b0}};
                        acc_i_q <= {ACC_W{1'b0}};
                        cnt_q   <= {CNT_W{1'b0}};
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc_r_q <= acc_r_d;
                        acc_i_q <= acc_i_d;
                        cnt_q   <= cnt_q + CNT_ONE;
                    end
                    if (last_s) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b1;
                        out_real_q  <= res_r_s;
                        out_imag_q  <= res_i_s;
                        sat_q       <= clip_r_s | clip_i_s;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q == ST_ACCUM);
    assign out_valid = out_valid_q;
    assign out_real  = out_real_q;
    assign out_imag  = out_imag_q;
    assign sat       = sat_q;

endmodule

// File: tb/tb_complex_accum.sv
// Scoreboard bench for complex_accum: two instances (SHIFT=0 and SHIFT=8) share
// stimulus; a reference model computes each frame result from the sample sums.
module tb_complex_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = 8'd0;
    logic        in_valid = 1'b0;
    logic [15:0] in_real = 16'd0;
    logic [15:0] in_imag = 16'd0;

    logic        busy0, ov0, sat0, busy8, ov8, sat8;
    logic [15:0] ore0, oim0, ore8, oim8;

    typedef struct {
        int re;
        int im;
        int sat;
    } res_t;

    res_t exp0[$];
    res_t exp8[$];
    res_t last0 = '{0, 0, 0};
    res_t last8 = '{0, 0, 0};
    int   q_re[$];
    int   q_im[$];
    int   checks = 0;
    int   fails  = 0;

    complex_accum #(.SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
        .in_real(in_real), .in_imag(in_imag), .busy(busy0), .out_valid(ov0),
        .out_real(ore0), .out_imag(oim0), .sat(sat0)
    );

    complex_accum #(.SHIFT(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .len(len), .in_valid(in_valid),
        .in_real(in_real), .in_imag(in_imag), .busy(busy8), .out_valid(ov8),
        .out_real(ore8), .out_imag(oim8), .sat(sat8)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint floor_div(input longint a, input longint d);
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic longint clamp16(input longint v, inout int clipped);
        if (v > 32767) begin
            clipped = 1;
            return 32767;
        end
        if (v < -32768) begin
            clipped = 1;
            return -32768;
        end
        return v;
    endfunction

    function automatic res_t ref_out(input longint sr, input longint si, input int sh);
        res_t   r;
        longint d;
        int     c;
        d    = longint'(1) << sh;
        c    = 0;
        r.re = int'(clamp16(floor_div(sr, d), c));
        r.im = int'(clamp16(floor_div(si, d), c));
        r.sat = c;
        return r;
    endfunction

    function automatic int rnd_val();
        case ($urandom_range(5))
            0:       return 32767;
            1:       return -32768;
            default: return int'($urandom_range(65535)) - 32768;
        endcase
    endfunction

    // Monitor: each output pulse is compared against the oldest pending result.
    always @(negedge clk) begin
        res_t e;
        if (ov0) begin
            if (exp0.size() == 0) begin
                chk("unexpected_out_valid_s0", 1, 0);
            end else begin
                e = exp0.pop_front();
                chk("out_real_s0", $signed(ore0), e.re);
                chk("out_imag_s0", $signed(oim0), e.im);
                chk("sat_s0", sat0, e.sat);
                last0 = e;
            end
        end
        if (ov8) begin
            if (exp8.size() == 0) begin
                chk("unexpected_out_valid_s8", 1, 0);
            end else begin
                e = exp8.pop_front();
                chk("out_real_s8", $signed(ore8), e.re);
                chk("out_imag_s8", $signed(oim8), e.im);
                chk("sat_s8", sat8, e.sat);
                last8 = e;
            end
        end
    end

    task automatic fill_const(input int n, input int re, input int im);
        q_re.delete();
        q_im.delete();
        for (int i = 0; i < n; i++) begin
            q_re.push_back(re);
            q_im.push_back(im);
        end
    endtask

    task automatic fill_rand(input int n);
        q_re.delete();
        q_im.delete();
        for (int i = 0; i < n; i++) begin
            q_re.push_back(rnd_val());
            q_im.push_back(rnd_val());
        end
    endtask

    // Reset with garbage on the inputs; leaves the clock at a falling edge.
    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b1;
        len      = 8'd3;
        in_valid = 1'b1;
        in_real  = 16'($urandom);
        in_imag  = 16'($urandom);
        repeat (2) @(negedge clk);
        chk("rst_busy_s0", busy0, 0);
        chk("rst_out_valid_s0", ov0, 0);
        chk("rst_out_real_s0", ore0, 0);
        chk("rst_out_imag_s0", oim0, 0);
        chk("rst_sat_s0", sat0, 0);
        chk("rst_busy_s8", busy8, 0);
        chk("rst_out_valid_s8", ov8, 0);
        chk("rst_out_real_s8", ore8, 0);
        chk("rst_sat_s8", sat8, 0);
        last0    = '{0, 0, 0};
        last8    = '{0, 0, 0};
        rst_n    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    // One frame from q_re/q_im. gap<0 gives random idle cycles; chain starts
    // in the current cycle (the previous frame's out_valid cycle).
    task automatic frame(input int n, input int gap, input bit chain, input bit noise);
        longint sr = 0;
        longint si = 0;
        int     idle;
        if (!chain) @(negedge clk);
        start    = 1'b1;
        len      = 8'(n);
        in_valid = 1'b1;
        in_real  = 16'($urandom);
        in_imag  = 16'($urandom);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) idle = 0;
            else if (gap >= 0) idle = gap;
            else idle = ($urandom_range(3) == 0) ? int'($urandom_range(3)) : 0;
            for (int k = 0; k < idle; k++) begin
                in_valid = 1'b0;
                in_real  = 16'($urandom);
                start    = noise ? 1'($urandom) : 1'b0;
                len      = 8'($urandom);
                chk("busy_gap_s0", busy0, 1);
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_real  = 16'(q_re[i]);
            in_imag  = 16'(q_im[i]);
            start    = noise ? 1'($urandom) : 1'b0;
            len      = 8'($urandom);
            chk("busy_s0", busy0, 1);
            chk("busy_s8", busy8, 1);
            sr += q_re[i];
            si += q_im[i];
            if (i == n - 1) begin
                exp0.push_back(ref_out(sr, si, 0));
                exp8.push_back(ref_out(sr, si, 8));
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("busy_after_last_s0", busy0, 0);
        chk("busy_after_last_s8", busy8, 0);
        chk("out_valid_latency_s0", ov0, 1);
        chk("out_valid_latency_s8", ov8, 1);
    endtask

    initial begin
        int n;
        do_reset();

        q_re = '{1, 2, 3, 4};
        q_im = '{-1, -2, -3, -4};
        frame(4, 0, 1'b0, 1'b0);
        fill_const(3, 32767, 32767);
        frame(3, 1, 1'b0, 1'b0);
        fill_const(3, -32768, -32768);
        frame(3, 1, 1'b0, 1'b0);
        fill_const(2, 1000, -1000);
        frame(2, 0, 1'b0, 1'b0);
        fill_const(255, 32767, -32768);
        frame(255, 0, 1'b0, 1'b0);

        // Back-to-back frames, second start in the first's out_valid cycle.
        fill_rand(2);
        frame(2, 0, 1'b0, 1'b0);
        fill_rand(2);
        frame(2, 0, 1'b1, 1'b0);
        fill_const(255, -32768, 32767);
        frame(255, 0, 1'b1, 1'b1);

        // Zero-length start is ignored and in_valid in idle does nothing.
        @(negedge clk);
        start = 1'b1;
        len   = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("len0_busy_s0", busy0, 0);
        chk("len0_busy_s8", busy8, 0);
        in_valid = 1'b1;
        in_real  = 16'd100;
        repeat (3) @(negedge clk);
        in_valid = 1'b0;
        chk("len0_no_out_s0", ov0, 0);

        // Reset after two of four samples drops the frame.
        @(negedge clk);
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_real  = 16'd5000;
            in_imag  = 16'd7;
            @(negedge clk);
        end
        do_reset();
        fill_rand(4);
        frame(4, 0, 1'b0, 1'b0);

        for (int f = 0; f < 30; f++) begin
            n = ($urandom_range(3) == 0) ? int'($urandom_range(255, 200))
                                         : int'($urandom_range(12, 1));
            fill_rand(n);
            frame(n, -1, (f > 0) && ($urandom_range(1) == 1), 1'b1);
        end

        repeat (4) @(negedge clk);
        chk("pending_results_s0", exp0.size(), 0);
        chk("pending_results_s8", exp8.size(), 0);
        chk("hold_out_real_s0", $signed(ore0), last0.re);
        chk("hold_out_imag_s0", $signed(oim0), last0.im);
        chk("hold_out_real_s8", $signed(ore8), last8.re);
        chk("hold_sat_s8", sat8, last8.sat);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
